// File: rtl/ram_be_pipe_if.sv
// -----------------------------------------------------------------------------
// ram_be_pipe_if
//   Bus bundle for ram_be_pipe: one write port, one read port and the status
//   strobes. WIDTH and DEPTH must match the parameters of the attached RAM.
//
//   Signals (direction as seen from the RAM, i.e. the slave modport):
//     wr_en      in   1      write request
//     wr_addr    in   AW     write word address
//     wr_data    in   WIDTH  write data
//     wr_be      in   BW     byte enables; bit i covers wr_data[8i+7:8i]
//     rd_en      in   1      read request
//     rd_addr    in   AW     read word address
//     rd_data    out  WIDTH  read data, qualified by rd_valid
//     rd_valid   out  1      one-cycle strobe per accepted read
//     init_done  out  1      RAM cleared and accepting requests
//     addr_err   out  1      one-cycle pulse for an out-of-range request
// -----------------------------------------------------------------------------
interface ram_be_pipe_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = WIDTH / 8;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [BW-1:0]    wr_be;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             init_done;
  logic             addr_err;

  // Requester side (bus adapter / testbench).
  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, init_done, addr_err
  );

  // Storage side (the RAM).
  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, init_done, addr_err
  );
endinterface

// File: rtl/ram_be_pipe.sv
// -----------------------------------------------------------------------------
// ram_be_pipe
//   Single-clock simple-dual-port RAM with per-byte write enables, a 1- or
//   2-cycle pipelined read port with valid strobe, selectable same-address
//   read-during-write behaviour, out-of-range address detection and a
//   self-clearing init sweep after reset.
//
//   Parameters:
//     WIDTH    data width in bits, multiple of 8
//     DEPTH    number of words, any value >= 1
//     RD_LAT   read latency: 1 or 2 (2 adds one output register)
//     RW_MODE  same-address read+write: 0 = old data, 1 = merged new data
//
//   Ports:
//     clk      clock, all state on posedge
//     rst      asynchronous active-low reset
//     bus      ram_be_pipe_if.slave (write port, read port, status)
// -----------------------------------------------------------------------------
module ram_be_pipe #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int RD_LAT  = 1,
  parameter int RW_MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  ram_be_pipe_if.slave bus
);

  localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              BW        = WIDTH / 8;
  // Address compares are done one bit wider so DEPTH itself is representable
  // even when DEPTH is a power of two.
  localparam logic [AW:0]     DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [AW-1:0]    r_init_cnt;
  logic             r_init_done;
  logic             r_addr_err;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic             w_ready;
  logic             w_wr_in_range;
  logic             w_rd_in_range;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_err;
  logic             w_init_wr;
  logic             w_same_addr;
  logic [WIDTH-1:0] w_old_word;
  logic [WIDTH-1:0] w_merged;
  logic [WIDTH-1:0] w_rd_word;

  assign w_ready       = (r_state == ST_READY);
  assign w_wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_W);
  assign w_rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_W);

  // Requests are only honoured once the init sweep is finished.
  assign w_wr_ok   = w_ready & bus.wr_en & w_wr_in_range;
  // Out-of-range reads are still accepted so the requester always gets its
  // rd_valid; the data path forces them to zero.
  assign w_rd_ok   = w_ready & bus.rd_en;
  // Read and write errors in the same cycle collapse into a single pulse.
  assign w_err     = w_ready & ((bus.wr_en & ~w_wr_in_range) |
                                (bus.rd_en & ~w_rd_in_range));
  assign w_init_wr = (r_state == ST_INIT);

  assign w_old_word  = w_rd_in_range ? r_mem[bus.rd_addr] : '0;
  // w_wr_ok already implies an in-range write address, so equality here also
  // implies an in-range read address.
  assign w_same_addr = w_wr_ok & (bus.wr_addr == bus.rd_addr);

  // Word as it will look after this cycle's byte-enabled write.
  always_comb begin
    // NOTE: give every always_comb output a default before any conditional
    // assignment; a path that leaves it unassigned infers a latch.
    w_merged = w_old_word;
    for (int i = 0; i < BW; i++) begin
      if (bus.wr_be[i]) begin
        w_merged[8*i +: 8] = bus.wr_data[8*i +: 8];
      end
    end
  end

  assign w_rd_word = ((RW_MODE == 1) && w_same_addr) ? w_merged : w_old_word;

  // ---------------------------------------------------------------------------
  // Control FSM: init sweep, then READY until the next reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values regardless of statement order.
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_addr_err <= w_err;
      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          // Leave INIT on the same edge that clears the last word.
          if (r_init_cnt == LAST_ADDR) begin
            r_state     <= ST_READY;
            r_init_done <= 1'b1;
          end
        end
        ST_READY: begin
          r_init_done <= 1'b1;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch so it maps onto RAM macros; its
  // contents are defined by the init sweep instead.
  always_ff @(posedge clk) begin
    if (w_init_wr) begin
      r_mem[r_init_cnt] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < BW; i++) begin
        if (bus.wr_be[i]) begin
          r_mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline. rd_data only moves when a valid word arrives, so it holds
  // its last value between strobes. Reset flushes every stage.
  // ---------------------------------------------------------------------------
  if (RD_LAT == 2) begin : g_lat2
    logic [WIDTH-1:0] r_s1_data;
    logic             r_s1_valid;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_s1_data  <= '0;
        r_s1_valid <= 1'b0;
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_s1_valid <= w_rd_ok;
        if (w_rd_ok) begin
          r_s1_data <= w_rd_word;
        end
        r_rd_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_rd_data <= r_s1_data;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_ok;
        if (w_rd_ok) begin
          r_rd_data <= w_rd_word;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.init_done = r_init_done;
  assign bus.addr_err  = r_addr_err;

endmodule
